// File: rtl/pair_swap_seq.sv
// pair_swap_seq: groups a valid/ready word stream into swapped (c,d,gt) pairs behind an output FIFO
// Ports:
//   clk, rst_n                      clock, async active-low reset
//   in_data/in_valid/in_ready       word input handshake
//   flush                           drop a pending half-pair
//   out_c/out_d/out_gt              FIFO head: second word, first word, first>second
//   out_valid/out_ready             pair output handshake
//   pair_count                      pairs pushed since reset, mod 256
module pair_swap_seq #(
  parameter int W = 3,
  parameter int DEPTH = 2
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic [W-1:0] in_data,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic         flush,
  output logic [W-1:0] out_c,
  output logic [W-1:0] out_d,
  output logic         out_gt,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [7:0]   pair_count
);
  localparam int AW = $clog2(DEPTH);
  typedef enum logic {IDLE, HALF} state_t;
  state_t state_q, state_d;
  logic [W-1:0] hold_q, hold_d;
  logic [AW:0] wr_q, wr_d, rd_q, rd_d;
  logic [2*W:0] mem_q [DEPTH];
  logic [2*W:0] mem_d [DEPTH];
  logic [7:0] cnt_q, cnt_d;
  logic empty, full, in_fire, out_fire, push;
  // pointers carry one extra wrap bit so full and empty are distinguishable
  assign empty = wr_q == rd_q;
  assign full = (wr_q[AW] != rd_q[AW]) && (wr_q[AW-1:0] == rd_q[AW-1:0]);
  assign out_valid = !empty;
  assign out_fire = out_valid && out_ready;
  // a pop in the same cycle frees the slot the second word needs
  assign in_ready = rst_n && !flush && (state_q == IDLE || !full || out_fire);
  assign in_fire = in_valid && in_ready;
  assign push = in_fire && state_q == HALF;
  assign {out_gt, out_c, out_d} = empty ? '0 : mem_q[rd_q[AW-1:0]];
  assign pair_count = cnt_q;
  always_comb begin
    mem_d = mem_q;
    if (push) mem_d[wr_q[AW-1:0]] = {hold_q > in_data, in_data, hold_q};
    state_d = flush ? IDLE : in_fire ? (state_q == IDLE ? HALF : IDLE) : state_q;
    hold_d = flush ? '0 : (in_fire && state_q == IDLE) ? in_data : hold_q;
    wr_d = wr_q + (AW+1)'(push);
    rd_d = rd_q + (AW+1)'(out_fire);
    cnt_d = cnt_q + 8'(push);
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      hold_q <= '0;
      wr_q <= '0;
      rd_q <= '0;
      cnt_q <= '0;
      mem_q <= '{default: '0};
    end else begin
      state_q <= state_d;
      hold_q <= hold_d;
      wr_q <= wr_d;
      rd_q <= rd_d;
      cnt_q <= cnt_d;
      mem_q <= mem_d;
    end
  end
endmodule

// File: tb/tb_pair_swap_seq.sv
// tb_pair_swap_seq: directed stimulus with a queue scoreboard and an independent output monitor
module tb_pair_swap_seq;
  logic clk = 0, rst_n = 0, in_valid = 0, flush = 0, out_ready = 0, out_gt, out_valid, in_ready;
  logic [2:0] in_data = 0, out_c, out_d;
  logic [7:0] pair_count;
  logic [6:0] exp_q[$];
  logic [6:0] prev_val;
  logic prev_stall = 0;
  int n_cmp = 0, n_bad = 0, exp_pc = 0;

  pair_swap_seq #(.W(3), .DEPTH(2)) dut (
    .clk(clk), .rst_n(rst_n), .in_data(in_data), .in_valid(in_valid), .in_ready(in_ready),
    .flush(flush), .out_c(out_c), .out_d(out_d), .out_gt(out_gt), .out_valid(out_valid),
    .out_ready(out_ready), .pair_count(pair_count)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input int act, input int exp);
    n_cmp++;
    if (act != exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // expected entry packed as {c, d, gt}
  function automatic logic [6:0] ent(input logic [2:0] c, input logic [2:0] d, input logic gt);
    return {c, d, gt};
  endfunction

  task automatic send(input logic [2:0] w);
    int n = 0;
    in_data = w;
    in_valid = 1;
    do begin
      @(negedge clk);
      n++;
    end while (!in_ready && n < 200);
    if (!in_ready) chk("send_timeout", 0, 1);
    @(posedge clk);
    #1 in_valid = 0;
  endtask

  task automatic send_pair(input logic [2:0] a, input logic [2:0] b, input logic [6:0] e);
    send(a);
    exp_q.push_back(e);
    exp_pc++;
    send(b);
  endtask

  task automatic drain;
    int n = 0;
    while (exp_q.size() != 0 && n < 2000) begin
      @(negedge clk);
      n++;
    end
    chk("drain_empty", exp_q.size(), 0);
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset;
    @(posedge clk);
    #1 rst_n = 0;
    exp_q.delete();
    exp_pc = 0;
    @(posedge clk);
    #1 rst_n = 1;
  endtask

  always @(negedge clk) begin
    if (!rst_n) prev_stall = 0;
    else begin
      if (prev_stall) begin
        chk("stall_valid", out_valid, 1);
        chk("stall_hold", {out_c, out_d, out_gt}, prev_val);
      end
      if (out_valid && out_ready) begin
        if (exp_q.size() == 0) chk("unexpected_out", 1, 0);
        else chk("out_pair", {out_c, out_d, out_gt}, exp_q.pop_front());
      end
      prev_stall = out_valid && !out_ready;
      prev_val = {out_c, out_d, out_gt};
    end
  end

  initial begin
    #2;
    chk("rst_out_valid", out_valid, 0);
    chk("rst_in_ready", in_ready, 0);
    chk("rst_pair_count", pair_count, 0);
    chk("rst_out_data", {out_c, out_d, out_gt}, 0);
    @(posedge clk);
    #1 rst_n = 1;
    out_ready = 1;
    // basic pair
    send_pair(3'd5, 3'd3, ent(3'd3, 3'd5, 1'b1));
    chk("t1_valid", out_valid, 1);
    chk("t1_data", {out_c, out_d, out_gt}, {3'd3, 3'd5, 1'b1});
    chk("t1_count", pair_count, 1);
    drain();
    // back-to-back, including equal words
    send_pair(3'd2, 3'd6, ent(3'd6, 3'd2, 1'b0));
    send_pair(3'd4, 3'd4, ent(3'd4, 3'd4, 1'b0));
    drain();
    chk("t2_count", pair_count, 3);
    // backpressure fills FIFO, one extra first word absorbed
    out_ready = 0;
    send_pair(3'd7, 3'd1, ent(3'd1, 3'd7, 1'b1));
    send_pair(3'd2, 3'd5, ent(3'd5, 3'd2, 1'b0));
    send(3'd6);
    in_data = 3'd3;
    in_valid = 1;
    @(negedge clk);
    chk("bp_in_ready_lo", in_ready, 0);
    @(negedge clk);
    chk("bp_in_ready_lo2", in_ready, 0);
    chk("bp_out_valid", out_valid, 1);
    chk("bp_count", pair_count, 5);
    @(posedge clk);
    #1 out_ready = 1;
    @(negedge clk);
    chk("bp_in_ready_pop", in_ready, 1);
    exp_q.push_back(ent(3'd3, 3'd6, 1'b1));
    exp_pc++;
    @(posedge clk);
    #1 out_ready = 0;
    in_valid = 0;
    @(negedge clk);
    chk("bp_after_count", pair_count, 6);
    @(posedge clk);
    #1 out_ready = 1;
    send_pair(3'd4, 3'd0, ent(3'd0, 3'd4, 1'b1));
    drain();
    // flush drops the half-pair and blocks input that cycle
    send(3'd7);
    in_data = 3'd1;
    in_valid = 1;
    flush = 1;
    @(negedge clk);
    chk("flush_in_ready", in_ready, 0);
    @(posedge clk);
    #1 flush = 0;
    in_valid = 0;
    send_pair(3'd2, 3'd3, ent(3'd3, 3'd2, 1'b0));
    drain();
    chk("flush_count", pair_count, exp_pc);
    chk("flush_count_abs", pair_count, 8);
    // async reset mid-pair with a pair in the FIFO
    out_ready = 0;
    send_pair(3'd5, 3'd6, ent(3'd6, 3'd5, 1'b0));
    send(3'd1);
    #2 rst_n = 0;
    #1;
    chk("mid_rst_valid", out_valid, 0);
    chk("mid_rst_count", pair_count, 0);
    chk("mid_rst_data", {out_c, out_d, out_gt}, 0);
    chk("mid_rst_in_ready", in_ready, 0);
    exp_q.delete();
    exp_pc = 0;
    @(posedge clk);
    #1 rst_n = 1;
    out_ready = 1;
    send_pair(3'd1, 3'd0, ent(3'd0, 3'd1, 1'b1));
    drain();
    chk("mid_rst_after_count", pair_count, 1);
    // counter wrap over 257 pairs
    do_reset();
    out_ready = 1;
    for (int i = 0; i < 257; i++) begin
      logic [2:0] a, b;
      a = 3'(i);
      b = 3'(i * 3 + 1);
      send_pair(a, b, ent(b, a, a > b));
    end
    drain();
    chk("wrap_count", pair_count, 1);
    chk("wrap_model", pair_count, exp_pc % 256);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL global_timeout: got running expected finished");
    $fatal(1);
  end
endmodule
